uart_rx_ext: RTL and testbench

Parametrised UART receiver with AXI4-Stream output. It supports 5–9 data bits, optional even/odd parity, 1 or 2 stop bits, three-sample majority voting, false-start rejection and break detection. Received words pass through an internal output FIFO. It is a drop-in successor to the existing 8N1 receiver, sitting between the pad-side `rxd` pin and any AXI-Stream consumer.

---
 rtl/uart_rx_ext.sv | 238 +++++++++++++++++++++++
 tb/tb_uart_rx_ext.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ext.sv
// UART receiver (5-9 data bits, optional parity, 1/2 stop bits) with majority-voted
// sampling, false-start rejection, break detection and an AXI4-Stream output FIFO.
module uart_rx_ext #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic [DATA_WIDTH-1:0]       m_axis_tdata,
  output logic                        m_axis_tuser,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  input  logic                        rxd,
  input  logic [15:0]                 prescale,
  input  logic [1:0]                  parity_mode,
  input  logic                        stop_bits,
  output logic                        busy,
  output logic                        overrun_error,
  output logic                        frame_error,
  output logic                        parity_error,
  output logic                        break_detect,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int CW = 19;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = DATA_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t r_state, w_state_nxt;

  logic r_sync1, r_sync2;
  logic w_rxs;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
    end
  end
  assign w_rxs = r_sync2;

  logic [CW-1:0]         r_cnt, r_bit_period;
  logic [1:0]            r_parity_mode;
  logic                  r_stop_two;
  logic                  r_s0, r_s1;
  logic [3:0]            r_bit_idx;
  logic                  r_stop_idx, r_stop_bad;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_par_bit;
  logic                  r_push, r_push_user;
  logic [DATA_WIDTH-1:0] r_push_data;
  logic                  r_perr_p, r_frame_p, r_break_p;

  logic [CW-1:0] w_half;
  logic          w_at_s0, w_at_s1, w_at_dec, w_at_end;
  logic          w_maj, w_par_en, w_perr, w_stop_fail, w_break_cond;
  logic          w_latch_cfg, w_shift, w_store_par, w_stop_zero;
  logic          w_push_set, w_frame_set, w_break_set;

  assign w_half   = r_bit_period >> 1;
  assign w_at_s0  = (r_cnt == w_half - 19'd1);
  assign w_at_s1  = (r_cnt == w_half);
  assign w_at_dec = (r_cnt == w_half + 19'd1);
  assign w_at_end = (r_cnt == r_bit_period - 19'd1);

  // Third sample is the live synchronized value at the decision count.
  assign w_maj = (r_s0 & r_s1) | (r_s0 & w_rxs) | (r_s1 & w_rxs);

  assign w_par_en     = (r_parity_mode == 2'b01) || (r_parity_mode == 2'b10);
  assign w_perr       = w_par_en & ((^r_data) ^ r_par_bit ^ (r_parity_mode == 2'b10));
  assign w_stop_fail  = r_stop_bad | ~w_maj;
  assign w_break_cond = (r_data == '0) && (!w_par_en || !r_par_bit);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_latch_cfg = 1'b0;
    w_shift     = 1'b0;
    w_store_par = 1'b0;
    w_stop_zero = 1'b0;
    w_push_set  = 1'b0;
    w_frame_set = 1'b0;
    w_break_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rxs) begin
          w_latch_cfg = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_at_dec && w_maj) w_state_nxt = S_IDLE;
        else if (w_at_end)     w_state_nxt = S_DATA;
      end
      S_DATA: begin
        w_shift = w_at_dec;
        if (w_at_end && r_bit_idx == 4'(DATA_WIDTH - 1))
          w_state_nxt = w_par_en ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        w_store_par = w_at_dec;
        if (w_at_end) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_at_dec) begin
          if (r_stop_two && !r_stop_idx) begin
            w_stop_zero = ~w_maj;
          end else if (!w_stop_fail) begin
            w_push_set  = 1'b1;
            w_state_nxt = S_IDLE;
          end else if (w_break_cond) begin
            w_break_set = 1'b1;
            w_state_nxt = S_WAIT_HIGH;
          end else begin
            w_frame_set = 1'b1;
            w_state_nxt = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        if (w_rxs) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt         <= '0;
      r_bit_period  <= '0;
      r_parity_mode <= 2'b00;
      r_stop_two    <= 1'b0;
      r_s0          <= 1'b1;
      r_s1          <= 1'b1;
      r_bit_idx     <= '0;
      r_stop_idx    <= 1'b0;
      r_stop_bad    <= 1'b0;
      r_data        <= '0;
      r_par_bit     <= 1'b0;
      r_push        <= 1'b0;
      r_push_user   <= 1'b0;
      r_push_data   <= '0;
      r_perr_p      <= 1'b0;
      r_frame_p     <= 1'b0;
      r_break_p     <= 1'b0;
    end else begin
      r_cnt <= (r_state == S_IDLE || w_at_end) ? '0 : r_cnt + 19'd1;
      if (w_at_s0) r_s0 <= w_rxs;
      if (w_at_s1) r_s1 <= w_rxs;
      if (w_latch_cfg) begin
        r_bit_period  <= {prescale, 3'b000};
        r_parity_mode <= parity_mode;
        r_stop_two    <= stop_bits;
        r_bit_idx     <= '0;
        r_stop_idx    <= 1'b0;
        r_stop_bad    <= 1'b0;
        r_data        <= '0;
        r_par_bit     <= 1'b0;
      end
      if (w_shift)                          r_data     <= {w_maj, r_data[DATA_WIDTH-1:1]};
      if (r_state == S_DATA && w_at_end)    r_bit_idx  <= r_bit_idx + 4'd1;
      if (w_store_par)                      r_par_bit  <= w_maj;
      if (r_state == S_STOP && w_at_end)    r_stop_idx <= 1'b1;
      if (w_stop_zero)                      r_stop_bad <= 1'b1;
      r_push <= w_push_set;
      if (w_push_set) begin
        r_push_data <= r_data;
        r_push_user <= w_perr;
      end
      r_perr_p  <= w_push_set & w_perr;
      r_frame_p <= w_frame_set;
      r_break_p <= w_break_set;
    end
  end

  // Output FIFO: power-of-two depth, pointers wrap naturally.
  logic [FW-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_full, w_pop, w_wr_en;
  logic [FW-1:0] w_head;

  assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_pop   = m_axis_tvalid & m_axis_tready;
  assign w_wr_en = r_push & (~w_full | w_pop);

  // NOTE: storage is not reset; the reset pointers/count define occupancy and tdata is masked while empty.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= {r_push_user, r_push_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head        = r_mem[r_rd_ptr];
  assign m_axis_tvalid = (r_count != '0);
  assign m_axis_tdata  = m_axis_tvalid ? w_head[DATA_WIDTH-1:0] : '0;
  assign m_axis_tuser  = m_axis_tvalid ? w_head[FW-1] : 1'b0;
  assign fifo_count    = r_count;

  assign busy          = (r_state != S_IDLE);
  assign overrun_error = r_push & w_full & ~w_pop;
  assign frame_error   = r_frame_p;
  assign parity_error  = r_perr_p;
  assign break_detect  = r_break_p;

endmodule

// File: tb/tb_uart_rx_ext.sv
// Directed bench for uart_rx_ext: serial frames are driven on rxd and the received
// words are checked against a scoreboard filled as each frame is sent.
`timescale 1ns/1ps
module tb_uart_rx_ext;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rxd8, rxd7, tready8, tready7;
  logic [15:0] prescale;
  logic [1:0]  parity_mode;
  logic        stop_bits;

  logic [7:0] tdata8;
  logic       tuser8, tvalid8, busy8, ovr8, fe8, pe8, brk8;
  logic [2:0] cnt8;
  logic [6:0] tdata7;
  logic       tuser7, tvalid7, busy7, ovr7, fe7, pe7, brk7;
  logic [2:0] cnt7;

  uart_rx_ext #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) dut8 (
    .clk(clk), .rst(rst),
    .m_axis_tdata(tdata8), .m_axis_tuser(tuser8), .m_axis_tvalid(tvalid8), .m_axis_tready(tready8),
    .rxd(rxd8), .prescale(prescale), .parity_mode(parity_mode), .stop_bits(stop_bits),
    .busy(busy8), .overrun_error(ovr8), .frame_error(fe8), .parity_error(pe8),
    .break_detect(brk8), .fifo_count(cnt8)
  );

  uart_rx_ext #(.DATA_WIDTH(7), .FIFO_DEPTH(4)) dut7 (
    .clk(clk), .rst(rst),
    .m_axis_tdata(tdata7), .m_axis_tuser(tuser7), .m_axis_tvalid(tvalid7), .m_axis_tready(tready7),
    .rxd(rxd7), .prescale(prescale), .parity_mode(parity_mode), .stop_bits(stop_bits),
    .busy(busy7), .overrun_error(ovr7), .frame_error(fe7), .parity_error(pe7),
    .break_detect(brk7), .fifo_count(cnt7)
  );

  int errors = 0;
  int checks = 0;
  int ovr_cnt = 0, fe_cnt = 0, pe_cnt = 0, brk_cnt = 0;
  int pe7_cnt = 0, fe7_cnt = 0;

  logic [8:0] exp8[$];
  logic [7:0] exp7[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard and pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (ovr8) ovr_cnt++;
      if (fe8)  fe_cnt++;
      if (pe8)  pe_cnt++;
      if (brk8) brk_cnt++;
      if (pe7)  pe7_cnt++;
      if (fe7)  fe7_cnt++;
      if (tvalid8 && tready8) begin
        check("sb8_word_pending", exp8.size() != 0, 1);
        if (exp8.size() != 0) check("sb8_word", {tuser8, tdata8}, exp8.pop_front());
      end
      if (tvalid7 && tready7) begin
        check("sb7_word_pending", exp7.size() != 0, 1);
        if (exp7.size() != 0) check("sb7_word", {tuser7, tdata7}, exp7.pop_front());
      end
    end
  end

  // par < 0 means no parity bit; pop_at >= 0 raises tready8 for that one cycle of the frame.
  task automatic send_frame(input bit to7, input logic [8:0] data, input int nbits, input int par,
                            input int nstop, input logic stop_val, input logic tail_val,
                            input int pop_at);
    logic bits[$];
    int   b;
    int   n;
    b = int'(prescale) * 8;
    bits.push_back(1'b0);
    for (int i = 0; i < nbits; i++) bits.push_back(data[i]);
    if (par >= 0) bits.push_back(par[0]);
    for (int i = 0; i < nstop; i++) bits.push_back(stop_val);
    bits.push_back(tail_val);
    n = 0;
    foreach (bits[k]) begin
      for (int c = 0; c < b; c++) begin
        if (to7) rxd7 = bits[k];
        else     rxd8 = bits[k];
        if (n == pop_at)                        tready8 = 1'b1;
        else if (pop_at >= 0 && n == pop_at + 1) tready8 = 1'b0;
        n++;
        tick();
      end
    end
  endtask

  task automatic wait_drain(input string tag);
    int t = 0;
    while ((exp8.size() != 0 || exp7.size() != 0) && t < 2000) begin
      tick();
      t++;
    end
    check(tag, exp8.size() + exp7.size(), 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    int snap;
    rst = 1'b1; rxd8 = 1'b1; rxd7 = 1'b1; tready8 = 1'b1; tready7 = 1'b1;
    prescale = 16'd1; parity_mode = 2'b00; stop_bits = 1'b0;
    tick(3);
    check("rst_tvalid", tvalid8, 0);
    check("rst_tdata", tdata8, 0);
    check("rst_tuser", tuser8, 0);
    check("rst_count", cnt8, 0);
    check("rst_busy", busy8, 0);
    check("rst_pulses", {ovr8, fe8, pe8, brk8}, 0);
    rst = 1'b0;
    tick(4);

    // 8N1 back-to-back words
    exp8.push_back({1'b0, 8'hA5});
    send_frame(0, 9'h0A5, 8, -1, 1, 1'b1, 1'b1, -1);
    check("gap_busy", busy8, 0);
    exp8.push_back({1'b0, 8'h3C});
    send_frame(0, 9'h03C, 8, -1, 1, 1'b1, 1'b1, -1);
    wait_drain("8n1_drain");
    check("8n1_no_errors", ovr_cnt + fe_cnt + pe_cnt + brk_cnt, 0);

    // 7 data bits, even parity, two stop bits
    parity_mode = 2'b01; stop_bits = 1'b1;
    exp7.push_back({1'b1, 7'h03});
    send_frame(1, 9'h003, 7, 1, 2, 1'b1, 1'b1, -1);
    exp7.push_back({1'b0, 7'h03});
    send_frame(1, 9'h003, 7, 0, 2, 1'b1, 1'b1, -1);
    wait_drain("par_drain");
    check("par_pulse_count", pe7_cnt, 1);
    check("par_no_frame_err", fe7_cnt, 0);

    // Framing error, line held low past the stop bit
    parity_mode = 2'b00; stop_bits = 1'b0;
    send_frame(0, 9'h055, 8, -1, 1, 1'b0, 1'b0, -1);
    tick(16);
    check("fe_busy_held", busy8, 1);
    check("fe_pulse", fe_cnt, 1);
    check("fe_count", cnt8, 0);
    check("fe_no_break", brk_cnt, 0);
    rxd8 = 1'b1;
    tick(4);
    check("fe_busy_release", busy8, 0);

    // Break: 20 bit times low, then a normal frame
    rxd8 = 1'b0;
    tick(160);
    check("brk_busy_held", busy8, 1);
    check("brk_pulse", brk_cnt, 1);
    check("brk_no_push", cnt8, 0);
    check("brk_no_frame_err", fe_cnt, 1);
    rxd8 = 1'b1;
    tick(4);
    check("brk_busy_release", busy8, 0);
    exp8.push_back({1'b0, 8'h81});
    send_frame(0, 9'h081, 8, -1, 1, 1'b1, 1'b1, -1);
    wait_drain("brk_recovery");

    // Overrun with the consumer stalled
    tready8 = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp8.push_back({1'b0, 8'(i)});
      send_frame(0, 9'(i), 8, -1, 1, 1'b1, 1'b1, -1);
    end
    check("ovr_count_full", cnt8, 4);
    check("ovr_pulse", ovr_cnt, 1);
    check("ovr_head_stable", tdata8, 8'h01);
    tready8 = 1'b1;
    wait_drain("ovr_drain");
    check("ovr_empty", cnt8, 0);

    // Pop coincides with the push into a full FIFO
    tready8 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      exp8.push_back({1'b0, 8'(i)});
      send_frame(0, 9'(i), 8, -1, 1, 1'b1, 1'b1, -1);
    end
    exp8.push_back({1'b0, 8'h05});
    send_frame(0, 9'h005, 8, -1, 1, 1'b1, 1'b1, 81);
    check("coinc_no_overrun", ovr_cnt, 1);
    check("coinc_count", cnt8, 4);
    tready8 = 1'b1;
    wait_drain("coinc_drain");

    // prescale=4: short glitch is a false start
    prescale = 16'd4;
    snap = ovr_cnt + fe_cnt + pe_cnt + brk_cnt;
    rxd8 = 1'b0;
    tick(3);
    rxd8 = 1'b1;
    check("glitch_start_seen", busy8, 1);
    t = 0;
    while (busy8 && t < 32) begin
      tick();
      t++;
    end
    check("glitch_busy_drop", busy8, 0);
    check("glitch_no_push", cnt8, 0);
    check("glitch_no_flags", ovr_cnt + fe_cnt + pe_cnt + brk_cnt, snap);

    // Reset in the middle of a data bit, with a word already queued
    tready8 = 1'b0;
    send_frame(0, 9'h011, 8, -1, 1, 1'b1, 1'b1, -1);
    check("pre_rst_count", cnt8, 1);
    check("pre_rst_head", tdata8, 8'h11);
    rxd8 = 1'b0; tick(32);
    rxd8 = 1'b1; tick(32);
    rxd8 = 1'b0; tick(16);
    check("mid_frame_busy", busy8, 1);
    rst = 1'b1; rxd8 = 1'b1;
    tick(2);
    check("mid_rst_busy", busy8, 0);
    check("mid_rst_tvalid", tvalid8, 0);
    check("mid_rst_tdata", {tuser8, tdata8}, 0);
    check("mid_rst_count", cnt8, 0);
    check("mid_rst_pulses", {ovr8, fe8, pe8, brk8}, 0);
    rst = 1'b0;
    tick(8);
    check("post_rst_no_pulse", ovr_cnt + fe_cnt + pe_cnt + brk_cnt, snap);
    tready8 = 1'b1;
    exp8.push_back({1'b0, 8'h5A});
    send_frame(0, 9'h05A, 8, -1, 1, 1'b1, 1'b1, -1);
    wait_drain("post_rst_frame");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
